// File: rtl/cp0_exception_unit.sv
// CP0 exception/interrupt unit for the commit stage: holds Status, Cause, EPC,
// BadVAddr, Count and Compare, synchronises hardware interrupt lines, runs the
// Count/Compare timer and arbitrates interrupts against synchronous exceptions.
module cp0_exception_unit #(
    parameter int NUM_HW_IRQ      = 6,
    parameter int IRQ_SYNC_STAGES = 2,
    parameter int COUNT_DIV       = 2,
    parameter int TIMER_IRQ_LINE  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_HW_IRQ-1:0] hw_irq,
    input  logic                  commit_valid,
    input  logic                  stall,
    input  logic [31:0]           commit_pc,
    input  logic                  commit_is_ds,
    input  logic                  commit_exc,
    input  logic [4:0]            commit_exccode,
    input  logic [31:0]           commit_badvaddr,
    input  logic                  commit_eret,
    input  logic                  mtc0_we,
    input  logic [4:0]            mtc0_addr,
    input  logic [31:0]           mtc0_wdata,
    input  logic [4:0]            mfc0_addr,
    output logic [31:0]           mfc0_rdata,
    output logic                  exc_taken,
    output logic [31:0]           exc_vector,
    output logic                  eret_taken,
    output logic [31:0]           eret_target,
    output logic [31:0]           status_out,
    output logic [31:0]           cause_out
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [31:0] VECTOR_BOOT   = 32'hBFC0_0380;
    localparam logic [31:0] VECTOR_NORMAL = 32'h8000_0180;

    // BEV is hard-wired: this core always runs its handlers from the boot ROM
    localparam logic STATUS_BEV = 1'b1;

    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    // Interrupt synchroniser chain, one row per stage
    logic [NUM_HW_IRQ-1:0] sync_q [IRQ_SYNC_STAGES];
    logic [5:0]            hw_sync_ext;
    logic [5:0]            ti_mask;

    // Architectural state
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic        ti_q, ti_d;
    logic [5:0]  ip_hw_q;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [DIV_W-1:0] div_q, div_d;

    // Derived control
    logic [7:0] ip_view;
    logic       commit;
    logic       int_req;
    logic       mtc0_commit;
    logic       count_wr;
    logic       compare_wr;
    logic       div_wrap;

    // Widen the synchronised lines to the six IP slots and fold in the timer
    always_comb begin
        hw_sync_ext = '0;
        hw_sync_ext[NUM_HW_IRQ-1:0] = sync_q[IRQ_SYNC_STAGES-1];
        ti_mask = 6'({5'b0, ti_q} << TIMER_IRQ_LINE);
    end

    assign ip_view = {ip_hw_q | ti_mask, ip_sw_q};

    assign commit      = commit_valid & ~stall;
    assign int_req     = (|(ip_view & im_q)) & ie_q & ~exl_q;
    assign exc_taken   = commit & (int_req | commit_exc);
    assign exc_vector  = STATUS_BEV ? VECTOR_BOOT : VECTOR_NORMAL;
    assign eret_taken  = commit & commit_eret & ~exc_taken;
    assign eret_target = epc_q;
    assign mtc0_commit = commit & mtc0_we & ~exc_taken;
    assign count_wr    = mtc0_commit && (mtc0_addr == REG_COUNT);
    assign compare_wr  = mtc0_commit && (mtc0_addr == REG_COMPARE);
    assign div_wrap    = (div_q == DIV_LAST);

    assign status_out = {9'b0, STATUS_BEV, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_out  = {bd_q, ti_q, 14'b0, ip_view, 1'b0, exccode_q, 2'b0};

    // Register read port shows committed state only
    always_comb begin
        mfc0_rdata = '0;
        case (mfc0_addr)
            REG_BADVADDR: mfc0_rdata = badvaddr_q;
            REG_COUNT:    mfc0_rdata = count_q;
            REG_COMPARE:  mfc0_rdata = compare_q;
            REG_STATUS:   mfc0_rdata = status_out;
            REG_CAUSE:    mfc0_rdata = cause_out;
            REG_EPC:      mfc0_rdata = epc_q;
            default:      mfc0_rdata = '0;
        endcase
    end

    // Timer next state: divider, Count, Compare and the sticky TI flag
    always_comb begin
        div_d     = div_wrap ? '0 : div_q + DIV_W'(1);
        count_d   = div_wrap ? count_q + 32'd1 : count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (count_wr) begin
            count_d = mtc0_wdata;
            div_d   = '0;
        end
        if (compare_wr) begin
            compare_d = mtc0_wdata;
        end
        if (compare_wr) begin
            ti_d = 1'b0;
        end else if ((count_wr || div_wrap) && (count_d == compare_q)) begin
            ti_d = 1'b1;
        end
    end

    // Exception entry, ERET and CP0 writes in commit priority order
    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        ip_sw_d    = ip_sw_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        if (exc_taken) begin
            exccode_d = int_req ? 5'd0 : commit_exccode;
            if (!exl_q) begin
                epc_d = commit_is_ds ? (commit_pc - 32'd4) : commit_pc;
                bd_d  = commit_is_ds;
            end
            exl_d = 1'b1;
            if ((exccode_d == 5'd4) || (exccode_d == 5'd5)) begin
                badvaddr_d = commit_badvaddr;
            end
        end else begin
            if (eret_taken) begin
                exl_d = 1'b0;
            end
            if (mtc0_commit) begin
                case (mtc0_addr)
                    REG_STATUS: begin
                        im_d  = mtc0_wdata[15:8];
                        exl_d = mtc0_wdata[1];
                        ie_d  = mtc0_wdata[0];
                    end
                    REG_CAUSE: ip_sw_d = mtc0_wdata[9:8];
                    REG_EPC:   epc_d   = mtc0_wdata;
                    default:   ;
                endcase
            end
        end
    end

    // Interrupt line synchroniser and the hardware IP capture flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < IRQ_SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            ip_hw_q <= '0;
        end else begin
            sync_q[0] <= hw_irq;
            for (int s = 1; s < IRQ_SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            ip_hw_q <= hw_sync_ext;
        end
    end

    // Timer registers keep running even while the commit stage is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    // Status, Cause, EPC and BadVAddr registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exccode_q  <= '0;
            ip_sw_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            exccode_q  <= exccode_d;
            ip_sw_q    <= ip_sw_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Bench for cp0_exception_unit: redirects are scoreboarded by a negedge monitor,
// register state is checked directly after each committed step.
module tb_cp0_exception_unit;

    logic        clk;
    logic        rst;
    logic [5:0]  hw_irq;
    logic        commit_valid;
    logic        stall;
    logic [31:0] commit_pc;
    logic        commit_is_ds;
    logic        commit_exc;
    logic [4:0]  commit_exccode;
    logic [31:0] commit_badvaddr;
    logic        commit_eret;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_wdata;
    logic [4:0]  mfc0_addr;
    logic [31:0] mfc0_rdata;
    logic        exc_taken;
    logic [31:0] exc_vector;
    logic        eret_taken;
    logic [31:0] eret_target;
    logic [31:0] status_out;
    logic [31:0] cause_out;

    typedef struct packed {
        logic        is_exc;
        logic [31:0] addr;
        logic [7:0]  tag;
    } redirect_t;

    redirect_t   exp_q[$];
    redirect_t   mon_item;
    int          checks;
    int          failures;
    logic [31:0] count_before;
    logic [31:0] rd;

    cp0_exception_unit dut (
        .clk(clk),
        .rst(rst),
        .hw_irq(hw_irq),
        .commit_valid(commit_valid),
        .stall(stall),
        .commit_pc(commit_pc),
        .commit_is_ds(commit_is_ds),
        .commit_exc(commit_exc),
        .commit_exccode(commit_exccode),
        .commit_badvaddr(commit_badvaddr),
        .commit_eret(commit_eret),
        .mtc0_we(mtc0_we),
        .mtc0_addr(mtc0_addr),
        .mtc0_wdata(mtc0_wdata),
        .mfc0_addr(mfc0_addr),
        .mfc0_rdata(mfc0_rdata),
        .exc_taken(exc_taken),
        .exc_vector(exc_vector),
        .eret_taken(eret_taken),
        .eret_target(eret_target),
        .status_out(status_out),
        .cause_out(cause_out)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkReg(input string name, input logic [4:0] addr, input logic [31:0] expected);
        mfc0_addr = addr;
        #1;
        checkOutput(name, mfc0_rdata, expected);
    endtask

    task automatic setIdle();
        commit_valid    = 1'b0;
        stall           = 1'b0;
        commit_pc       = '0;
        commit_is_ds    = 1'b0;
        commit_exc      = 1'b0;
        commit_exccode  = '0;
        commit_badvaddr = '0;
        commit_eret     = 1'b0;
        mtc0_we         = 1'b0;
        mtc0_addr       = '0;
        mtc0_wdata      = '0;
    endtask

    // Drive one commit-stage cycle, then return 1 time unit after its edge
    task automatic applyStimulus(input logic [31:0] pc, input logic is_ds, input logic exc,
                                 input logic [4:0] code, input logic [31:0] bva, input logic eret,
                                 input logic we, input logic [4:0] addr, input logic [31:0] wdata);
        commit_valid    = 1'b1;
        stall           = 1'b0;
        commit_pc       = pc;
        commit_is_ds    = is_ds;
        commit_exc      = exc;
        commit_exccode  = code;
        commit_badvaddr = bva;
        commit_eret     = eret;
        mtc0_we         = we;
        mtc0_addr       = addr;
        mtc0_wdata      = wdata;
        @(posedge clk);
        #1;
        setIdle();
    endtask

    task automatic mtc0Write(input logic [4:0] addr, input logic [31:0] wdata);
        applyStimulus(32'h8000_0000, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, addr, wdata);
    endtask

    task automatic expectRedirect(input logic is_exc, input logic [31:0] addr, input logic [7:0] tag);
        redirect_t r;
        r.is_exc = is_exc;
        r.addr   = addr;
        r.tag    = tag;
        exp_q.push_back(r);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every redirect the DUT presents must match the next expected one
    always @(negedge clk) begin
        if (!rst && (exc_taken || eret_taken)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_redirect: got exc=%0b eret=%0b, expected none", exc_taken, eret_taken);
            end else begin
                mon_item = exp_q.pop_front();
                checkOutput($sformatf("redirect%0d_kind", mon_item.tag),
                            {30'b0, exc_taken, eret_taken}, {30'b0, mon_item.is_exc, ~mon_item.is_exc});
                checkOutput($sformatf("redirect%0d_addr", mon_item.tag),
                            exc_taken ? exc_vector : eret_target, mon_item.addr);
            end
        end
    end

    // Safety net so the run always ends
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario
    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        hw_irq    = '0;
        mfc0_addr = '0;
        setIdle();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_status", status_out, 32'h0040_0000);

        // Reset in the middle of counting
        mtc0Write(5'd9, 32'h0000_0010);
        checkReg("count_loaded", 5'd9, 32'h0000_0010);
        rst = 1'b1;
        checkReg("count_async_reset", 5'd9, 32'h0);
        checkOutput("status_async_reset", status_out, 32'h0040_0000);
        checkOutput("exc_taken_reset", {31'b0, exc_taken}, 32'h0);
        waitCycles(1);
        checkReg("count_held_reset", 5'd9, 32'h0);
        rst = 1'b0;

        // Timer interrupt on IP[7]
        mtc0Write(5'd11, 32'd3);
        mtc0Write(5'd12, 32'h0000_8001);
        mtc0Write(5'd9, 32'd0);
        waitCycles(5);
        checkOutput("ti_not_yet", {31'b0, cause_out[30]}, 32'h0);
        waitCycles(1);
        checkOutput("ti_and_ip7", cause_out, 32'h4000_8000);
        checkReg("count_at_match", 5'd9, 32'd3);
        expectRedirect(1'b1, 32'hBFC0_0380, 8'd1);
        applyStimulus(32'h8000_1000, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        checkReg("timer_epc", 5'd14, 32'h8000_1000);
        checkOutput("timer_cause", cause_out, 32'h4000_8000);
        checkOutput("timer_status", status_out, 32'h0040_8003);

        // Address error in a delay slot
        mtc0Write(5'd12, 32'h0);
        checkOutput("status_cleared", status_out, 32'h0040_0000);
        expectRedirect(1'b1, 32'hBFC0_0380, 8'd2);
        applyStimulus(32'h8000_0104, 1'b1, 1'b1, 5'd4, 32'h8000_0003, 1'b0, 1'b0, 5'd0, 32'h0);
        checkReg("ds_epc", 5'd14, 32'h8000_0100);
        checkReg("ds_badvaddr", 5'd8, 32'h8000_0003);
        checkOutput("ds_cause", cause_out, 32'hC000_8010);
        checkOutput("ds_status", status_out, 32'h0040_0002);

        // Nested exception keeps EPC, then ERET
        expectRedirect(1'b1, 32'hBFC0_0380, 8'd3);
        applyStimulus(32'h8000_0200, 1'b0, 1'b1, 5'd10, 32'h1234_5678, 1'b0, 1'b0, 5'd0, 32'h0);
        checkReg("nested_epc", 5'd14, 32'h8000_0100);
        checkReg("nested_badvaddr", 5'd8, 32'h8000_0003);
        checkOutput("nested_cause", cause_out, 32'hC000_8028);
        expectRedirect(1'b0, 32'h8000_0100, 8'd4);
        applyStimulus(32'h8000_0204, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        checkOutput("eret_status", status_out, 32'h0040_0000);

        // Hardware line 2 through the synchroniser, beating a same-cycle exception
        mtc0Write(5'd11, 32'hFFFF_0000);
        checkOutput("compare_clears_ti", cause_out, 32'h8000_0028);
        mtc0Write(5'd12, 32'h0000_1001);
        hw_irq = 6'b000100;
        waitCycles(2);
        checkOutput("ip4_not_yet", {31'b0, cause_out[12]}, 32'h0);
        waitCycles(1);
        checkOutput("ip4_risen", {31'b0, cause_out[12]}, 32'h1);
        expectRedirect(1'b1, 32'hBFC0_0380, 8'd5);
        applyStimulus(32'h8000_0300, 1'b0, 1'b1, 5'd12, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        checkOutput("irq_wins_cause", cause_out, 32'h0000_1000);
        checkReg("irq_wins_epc", 5'd14, 32'h8000_0300);
        checkOutput("irq_wins_status", status_out, 32'h0040_1003);

        // CP0 write suppressed by a pending interrupt
        expectRedirect(1'b0, 32'h8000_0300, 8'd6);
        applyStimulus(32'h8000_0304, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        checkOutput("eret2_status", status_out, 32'h0040_1001);
        expectRedirect(1'b1, 32'hBFC0_0380, 8'd7);
        applyStimulus(32'h8000_0400, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd11, 32'h1234_5678);
        checkReg("compare_suppressed", 5'd11, 32'hFFFF_0000);
        checkReg("suppress_epc", 5'd14, 32'h8000_0400);
        checkOutput("suppress_status", status_out, 32'h0040_1003);

        // Stall blocks commit but the timer keeps counting
        expectRedirect(1'b0, 32'h8000_0400, 8'd8);
        applyStimulus(32'h8000_0404, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        mfc0_addr = 5'd9;
        #1;
        count_before = mfc0_rdata;
        commit_valid   = 1'b1;
        stall          = 1'b1;
        commit_exc     = 1'b1;
        commit_exccode = 5'd12;
        commit_pc      = 32'h8000_0500;
        #1;
        checkOutput("stall_no_exc", {31'b0, exc_taken}, 32'h0);
        waitCycles(4);
        mfc0_addr = 5'd9;
        #1;
        rd = count_before + 32'd2;
        checkOutput("stall_count_runs", mfc0_rdata, rd);
        setIdle();
        checkOutput("stall_status", status_out, 32'h0040_1001);
        checkReg("stall_epc", 5'd14, 32'h8000_0400);

        hw_irq = '0;
        waitCycles(5);
        checkOutput("scoreboard_drained", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
